sr_bist_checker: RTL

Built-in self-test driver and checker for the latch-based serial delay line. It generates a PRBS7 stream onto the delay line's serial input, paced at the line's shift rate of one bit per 4 clocks. It samples the line's serial output and compares it against a locally regenerated, delay-aligned copy of the stream. It reports a pass/fail verdict, an error count and the index of the first mismatch. It sits beside the delay line in the top level: `tx_bit` drives the line input, and the line output returns on `rx_bit`.

---
 rtl/sr_bist_pkg.sv | 19 +
 rtl/prbs7_gen.sv | 27 ++
 rtl/sr_bist_checker.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sr_bist_pkg.sv
// Shared types and constants for the serial delay-line BIST checker.
// PRBS7 is x^7+x^6+1, Fibonacci form, output taken from bit 6.
package sr_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK,
        DONE
    } state_t;

    localparam logic [6:0] PRBS_SEED  = 7'h7F;
    localparam int         PRBS_TAP_A = 6;
    localparam int         PRBS_TAP_B = 5;

    localparam logic [15:0] ERR_SAT    = 16'hFFFF;
    localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 generator with step enable and synchronous seed load.
// Load wins over step.
module prbs7_gen
    import sr_bist_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic step,
    output logic bit_out
);

    logic [6:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= PRBS_SEED;
        end else if (load) begin
            lfsr <= PRBS_SEED;
        end else if (step) begin
            lfsr <= {lfsr[5:0], lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B]};
        end
    end

    assign bit_out = lfsr[6];

endmodule

// File: rtl/sr_bist_checker.sv
// BIST driver/checker for the latch-based serial delay line: sends PRBS7,
// compares the delayed return against a delay-aligned local copy.
module sr_bist_checker
    import sr_bist_pkg::*;
#(
    parameter int LATENCY    = 64,
    parameter int N_BITS     = 256,
    parameter int BIT_PERIOD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_bit,
    output logic        tx_bit,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx
);

    localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [PW-1:0] PH_LAST    = PW'(BIT_PERIOD - 1);
    localparam logic [15:0]   FILL_LAST  = 16'(LATENCY - 1);
    localparam logic [15:0]   CHECK_LAST = 16'(N_BITS - 1);

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] ph;
    logic [15:0]   cnt;
    logic [15:0]   err_next;
    logic          armed;
    logic          pend;
    logic          last;
    logic          req;
    logic          parked;
    logic          launch;
    logic          mism;
    logic          tx_load;
    logic          tx_step;
    logic          ref_load;
    logic          ref_step;
    logic          tx_prbs;
    logic          ref_prbs;

    prbs7_gen u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tx_load),
        .step    (tx_step),
        .bit_out (tx_prbs)
    );

    prbs7_gen u_ref (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ref_load),
        .step    (ref_step),
        .bit_out (ref_prbs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        last       = (ph == PH_LAST);
        parked     = (state == IDLE) || (state == DONE);
        // armed masks a start sampled on the first edge after reset release
        req        = pend || (start && armed);
        unique case (state)
            IDLE, DONE: if (req && last) next_state = FILL;
            FILL:       if (last && cnt == FILL_LAST) next_state = CHECK;
            CHECK:      if (last && cnt == CHECK_LAST) next_state = DONE;
            default:    next_state = IDLE;
        endcase
        launch   = parked && (next_state == FILL);
        mism     = (state == CHECK) && last && (rx_bit != ref_prbs);
        err_next = (mism && err_count != ERR_SAT) ? err_count + 16'd1
                                                   : err_count;
        tx_load  = parked && !launch;
        tx_step  = launch || (last && !parked);
        ref_load = (state != CHECK);
        ref_step = (state == CHECK) && last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph            <= '0;
            cnt           <= '0;
            armed         <= 1'b0;
            pend          <= 1'b0;
            tx_bit        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= NO_ERR_IDX;
        end else begin
            ph    <= last ? '0 : ph + PW'(1);
            armed <= 1'b1;
            pend  <= parked && req && !launch;
            busy  <= (next_state == FILL) || (next_state == CHECK);
            done  <= (next_state == DONE);
            if (tx_step) begin
                tx_bit <= (next_state == DONE) ? 1'b0 : tx_prbs;
            end
            if (launch) begin
                cnt           <= '0;
                pass          <= 1'b0;
                err_count     <= '0;
                first_err_idx <= NO_ERR_IDX;
            end else if (last && !parked) begin
                cnt <= (next_state != state) ? 16'd0 : cnt + 16'd1;
            end
            if (state == CHECK && last) begin
                err_count <= err_next;
                if (mism && first_err_idx == NO_ERR_IDX) begin
                    first_err_idx <= cnt;
                end
                if (next_state == DONE) begin
                    pass <= (err_next == 16'd0);
                end
            end
        end
    end

endmodule
